// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. One result bit per clock (radix-2):
// shift-add for multiplies, restoring shift-subtract for divides. Operands
// are converted to magnitudes, the core works unsigned, and the sign is
// re-applied once at the end.
module mdu_iterative #(
  parameter int XLEN   = 32,
  parameter int CYCLES = 34
) (
  input  logic            clock,
  input  logic            nReset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  // The SETUP edge already performs the first iteration, so CALC covers
  // counter values 1..LAST_CNT; this keeps start-to-done at CYCLES edges.
  localparam logic [4:0] LAST_CNT = 5'(CYCLES - 3);

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
    return n ? (-v) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (-v) : v;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            sign_q, sign_d;
  logic [XLEN-1:0] hi_q, lo_q, hi_d, lo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div, a_signed, b_signed, s1, s2;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN-1:0] step_hi, step_lo;
  logic [XLEN:0]   sum, sh;
  logic            ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] sel;

  // Operand decode and magnitudes; 0x80000000 negates to itself, read unsigned.
  always_comb begin
    is_div   = op_q[2];
    a_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) || (op_q == OP_DIV) || (op_q == OP_REM);
    b_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
    s1       = a_signed & a_q[XLEN-1];
    s2       = b_signed & b_q[XLEN-1];
    mag_a    = cond_neg(a_q, s1);
    mag_b    = cond_neg(b_q, s2);
    sign_d   = (op_q == OP_REM || op_q == OP_REMU) ? s1 : (s1 ^ s2);
  end

  // One radix-2 step; SETUP feeds it a freshly initialised accumulator.
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    if (state_q == S_SETUP) begin
      step_hi = '0;
      step_lo = is_div ? mag_a : mag_b;
    end
    sum = {1'b0, step_hi} + (step_lo[0] ? {1'b0, mag_a} : '0);
    sh  = {step_hi, step_lo[XLEN-1]};
    ge  = (sh >= {1'b0, mag_b});
    if (is_div) begin
      hi_d = ge ? (sh[XLEN-1:0] - mag_b) : sh[XLEN-1:0];
      lo_d = {step_lo[XLEN-2:0], ge};
    end else begin
      hi_d = sum[XLEN:1];
      lo_d = {sum[0], step_lo[XLEN-1:1]};
    end
  end

  // Sign fix-up and result selection; DIV by zero stays all ones.
  always_comb begin
    prod_fix = cond_neg2({hi_q, lo_q}, sign_q);
    case (op_q)
      OP_MUL:                         sel = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   sel = prod_fix[2*XLEN-1:XLEN];
      OP_DIV:                         sel = (b_q == '0) ? '1 : cond_neg(lo_q, sign_q);
      OP_DIVU:                        sel = lo_q;
      OP_REM:                         sel = cond_neg(hi_q, sign_q);
      default:                        sel = hi_q;
    endcase
  end

  // Sequencer: next state, iteration counter and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE:  if (start && !kill) state_d = S_SETUP;
      S_SETUP: begin
        cnt_d   = 5'd1;
        state_d = kill ? S_IDLE : S_CALC;
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (kill)                   state_d = S_IDLE;
        else if (cnt_q == LAST_CNT) state_d = S_FIX;
      end
      S_FIX: begin
        if (kill) state_d = S_IDLE;
        else begin
          state_d  = S_DONE;
          result_d = sel;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      if (state_q == S_IDLE && start && !kill) begin
        op_q  <= op;
        a_q   <= in1;
        b_q   <= in2;
        cnt_q <= '0;
      end
      if (state_q == S_SETUP) sign_q <= sign_d;
      if (state_q == S_SETUP || state_q == S_CALC) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: expected results are queued when an
// operation is issued and compared whenever done pulses.
module tb_mdu_iterative;

  logic        clock = 1'b0;
  logic        nReset, start, kill;
  logic [2:0]  op;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] scb[$];
  logic [31:0] last_res;

  always #5 clock = ~clock;

  mdu_iterative dut (
    .clock(clock), .nReset(nReset), .start(start), .kill(kill), .op(op),
    .in1(in1), .in2(in2), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, p;
    logic [63:0] u;
    logic signed [31:0] qa, qb;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    qa  = a;
    qb  = b;
    case (o)
      3'd0: return a * b;
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return qa / qb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return qa % qb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Any done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (scb.size() == 0) check("spurious_done", {31'b0, done}, 32'd0);
      else check("result", result, scb.pop_front());
    end
  end

  // Issue one operation at a negedge with busy low; optionally inject a
  // start with fresh operands at cycle 'intrude' while busy.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int intrude);
    logic [31:0] e;
    int k, gaps;
    e = model(o, a, b);
    op = o; in1 = a; in2 = b; start = 1'b1;
    scb.push_back(e);
    @(negedge clock);
    start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    op = 3'($urandom); in1 = $urandom; in2 = $urandom;
    k = 1; gaps = 0;
    while (!done && k < 60) begin
      @(negedge clock);
      k++;
      if (!busy) gaps++;
      if (k == intrude) begin
        start = 1'b1; op = 3'd5; in1 = 32'd1000; in2 = 32'd3;
      end else start = 1'b0;
    end
    start = 1'b0;
    check("latency", 32'(k), 32'd34);
    check("busy_gap", 32'(gaps), 32'd0);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    last_res = e;
    @(negedge clock);
    check("done_width", {31'b0, done}, 32'd0);
    check("busy_after_done", {31'b0, busy}, 32'd0);
  endtask

  task automatic do_kill(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int kc);
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < kc; k++) @(negedge clock);
    kill = 1'b1;
    @(negedge clock);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_done", {31'b0, done}, 32'd0);
    check("kill_result", result, last_res);
    repeat (40) @(negedge clock);
    check("kill_result_held", result, last_res);
  endtask

  task automatic do_reset_mid(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int rc);
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k < rc; k++) @(negedge clock);
    nReset = 1'b0;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clock);
    nReset = 1'b1;
    last_res = 32'd0;
    repeat (40) @(negedge clock);
    check("rst_result_held", result, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    nReset = 1'b0; start = 1'b0; kill = 1'b0; op = 3'd0; in1 = 32'd0; in2 = 32'd0;
    last_res = 32'd0;
    repeat (2) @(negedge clock);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    nReset = 1'b1;
    @(negedge clock);

    do_op(3'd0, 32'd7,        32'hFFFFFFFD, 0);
    do_op(3'd1, 32'h80000000, 32'h80000000, 0);
    do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'd4, 32'hFFFFFFF9, 32'd2,        0);
    do_op(3'd6, 32'hFFFFFFF9, 32'd2,        0);
    do_op(3'd5, 32'd100,      32'd7,        0);
    do_op(3'd7, 32'd100,      32'd7,        0);
    do_op(3'd4, 32'd5,        32'd0,        0);
    do_op(3'd6, 32'd5,        32'd0,        0);
    do_op(3'd4, 32'hFFFFFFFB, 32'd0,        0);
    do_op(3'd6, 32'hFFFFFFFB, 32'd0,        0);
    do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    do_op(3'd4, 32'd1000,     32'hFFFFFFF9, 10);
    do_op(3'd1, 32'h80000000, 32'h00000003, 0);

    do_kill(3'd4, 32'd12345, 32'd11, 15);
    do_reset_mid(3'd0, 32'd99, 32'd77, 20);

    for (int i = 0; i < 8; i++) do_op(3'($urandom), $urandom, $urandom, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", 32'(scb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
